// File: rtl/obi_mux_2_to_1.sv
// Two-controller to one-responder OBI mux with arbitration and in-order read response routing.
// Define OBI_MUX_FIXED_PRIORITY_EN for fixed priority (ctrl1 wins ties) instead of round-robin.
module obi_mux_2_to_1 #(
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctrl1_req_i,
  input  logic [31:0] ctrl1_addr_i,
  input  logic        ctrl1_we_i,
  input  logic [3:0]  ctrl1_be_i,
  input  logic [31:0] ctrl1_wdata_i,
  output logic        ctrl1_gnt_o,
  output logic        ctrl1_rvalid_o,
  output logic [31:0] ctrl1_rdata_o,
  input  logic        ctrl2_req_i,
  input  logic [31:0] ctrl2_addr_i,
  input  logic        ctrl2_we_i,
  input  logic [3:0]  ctrl2_be_i,
  input  logic [31:0] ctrl2_wdata_i,
  output logic        ctrl2_gnt_o,
  output logic        ctrl2_rvalid_o,
  output logic [31:0] ctrl2_rdata_o,
  output logic        port_req_o,
  output logic [31:0] port_addr_o,
  output logic        port_we_o,
  output logic [3:0]  port_be_o,
  output logic [31:0] port_wdata_o,
  input  logic        port_gnt_i,
  input  logic        port_rvalid_i,
  input  logic [31:0] port_rdata_i,
  output logic        resp_error_o
);

  typedef enum logic {SRC1 = 1'b0, SRC2 = 1'b1} src_e;

  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RESP_DEPTH) + 1;

  src_e            sel, sel_q, head;
  logic            hold_q, hold_d;
  src_e            ids_q [RESP_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            full, empty, sel_req, hs, push, pop;
`ifndef OBI_MUX_FIXED_PRIORITY_EN
  src_e            last_q;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A stalled address phase freezes the selection until its handshake completes.
  always_comb begin
    sel = SRC1;
    if (hold_q) begin
      sel = sel_q;
    end else if (ctrl1_req_i && ctrl2_req_i) begin
`ifdef OBI_MUX_FIXED_PRIORITY_EN
      sel = SRC1;
`else
      sel = (last_q == SRC1) ? SRC2 : SRC1;
`endif
    end else if (ctrl2_req_i) begin
      sel = SRC2;
    end
  end

  assign full  = (cnt_q == CW'(RESP_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = ids_q[rptr_q];

  always_comb begin
    sel_req      = (sel == SRC1) ? ctrl1_req_i   : ctrl2_req_i;
    port_addr_o  = (sel == SRC1) ? ctrl1_addr_i  : ctrl2_addr_i;
    port_we_o    = (sel == SRC1) ? ctrl1_we_i    : ctrl2_we_i;
    port_be_o    = (sel == SRC1) ? ctrl1_be_i    : ctrl2_be_i;
    port_wdata_o = (sel == SRC1) ? ctrl1_wdata_i : ctrl2_wdata_i;
    port_req_o   = sel_req && !full;
    hs           = port_req_o && port_gnt_i;
    ctrl1_gnt_o  = hs && (sel == SRC1);
    ctrl2_gnt_o  = hs && (sel == SRC2);
    push         = hs && !port_we_o;
    pop          = port_rvalid_i && !empty;
    hold_d       = hold_q;
    if (hs)              hold_d = 1'b0;
    else if (port_req_o) hold_d = 1'b1;
  end

  assign ctrl1_rvalid_o = pop && (head == SRC1);
  assign ctrl2_rvalid_o = pop && (head == SRC2);
  assign ctrl1_rdata_o  = port_rdata_i;
  assign ctrl2_rdata_o  = port_rdata_i;
  assign resp_error_o   = port_rvalid_i && empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= 1'b0;
      sel_q  <= SRC1;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
`ifndef OBI_MUX_FIXED_PRIORITY_EN
      last_q <= SRC2;
`endif
    end else begin
      hold_q <= hold_d;
      sel_q  <= sel;
`ifndef OBI_MUX_FIXED_PRIORITY_EN
      if (hs) last_q <= sel;
`endif
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) ids_q[wptr_q] <= sel;
  end

endmodule

// File: tb/tb_obi_mux_2_to_1.sv
// Self-checking bench for obi_mux_2_to_1: directed scenarios plus randomized OBI traffic
// checked against a queue-based reference model of arbitration and response routing.
module tb_obi_mux_2_to_1;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        ctrl1_req_i, ctrl1_we_i, ctrl2_req_i, ctrl2_we_i;
  logic [31:0] ctrl1_addr_i, ctrl1_wdata_i, ctrl2_addr_i, ctrl2_wdata_i;
  logic [3:0]  ctrl1_be_i, ctrl2_be_i;
  logic        ctrl1_gnt_o, ctrl1_rvalid_o, ctrl2_gnt_o, ctrl2_rvalid_o;
  logic [31:0] ctrl1_rdata_o, ctrl2_rdata_o;
  logic        port_req_o, port_we_o, port_gnt_i, port_rvalid_i, resp_error_o;
  logic [31:0] port_addr_o, port_wdata_o, port_rdata_i;
  logic [3:0]  port_be_o;

  obi_mux_2_to_1 #(.RESP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ctrl1_req_i(ctrl1_req_i), .ctrl1_addr_i(ctrl1_addr_i), .ctrl1_we_i(ctrl1_we_i),
    .ctrl1_be_i(ctrl1_be_i), .ctrl1_wdata_i(ctrl1_wdata_i), .ctrl1_gnt_o(ctrl1_gnt_o),
    .ctrl1_rvalid_o(ctrl1_rvalid_o), .ctrl1_rdata_o(ctrl1_rdata_o),
    .ctrl2_req_i(ctrl2_req_i), .ctrl2_addr_i(ctrl2_addr_i), .ctrl2_we_i(ctrl2_we_i),
    .ctrl2_be_i(ctrl2_be_i), .ctrl2_wdata_i(ctrl2_wdata_i), .ctrl2_gnt_o(ctrl2_gnt_o),
    .ctrl2_rvalid_o(ctrl2_rvalid_o), .ctrl2_rdata_o(ctrl2_rdata_o),
    .port_req_o(port_req_o), .port_addr_o(port_addr_o), .port_we_o(port_we_o),
    .port_be_o(port_be_o), .port_wdata_o(port_wdata_o), .port_gnt_i(port_gnt_i),
    .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i), .resp_error_o(resp_error_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: outstanding read sources in issue order, last granted, locked source.
  int q[$];
  int last_g = 2;
  int lock_src = 0;
  int m_s;
  bit m_hs, m_ereq, m_we, m_g1, m_g2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    ctrl1_req_i = 0; ctrl1_addr_i = '0; ctrl1_we_i = 0; ctrl1_be_i = '0; ctrl1_wdata_i = '0;
    ctrl2_req_i = 0; ctrl2_addr_i = '0; ctrl2_we_i = 0; ctrl2_be_i = '0; ctrl2_wdata_i = '0;
    port_gnt_i = 0; port_rvalid_i = 0; port_rdata_i = '0;
  endtask

  task automatic settle_check();
    bit sreq;
    #1;
    if (lock_src != 0)                  m_s = lock_src;
    else if (ctrl1_req_i && ctrl2_req_i) m_s = (last_g == 1) ? 2 : 1;
    else if (ctrl2_req_i)                m_s = 2;
    else                                 m_s = 1;
    sreq   = (m_s == 1) ? ctrl1_req_i : ctrl2_req_i;
    m_we   = (m_s == 1) ? ctrl1_we_i : ctrl2_we_i;
    m_ereq = sreq && (q.size() < DEPTH);
    m_hs   = m_ereq && port_gnt_i;
    m_g1   = m_hs && (m_s == 1);
    m_g2   = m_hs && (m_s == 2);
    if (!rst_i) begin
      check("port_req", 32'(port_req_o), 32'(m_ereq));
      check("gnt1", 32'(ctrl1_gnt_o), 32'(m_g1));
      check("gnt2", 32'(ctrl2_gnt_o), 32'(m_g2));
      check("rvalid1", 32'(ctrl1_rvalid_o), 32'(port_rvalid_i && q.size() > 0 && q[0] == 1));
      check("rvalid2", 32'(ctrl2_rvalid_o), 32'(port_rvalid_i && q.size() > 0 && q[0] == 2));
      check("resp_err", 32'(resp_error_o), 32'(port_rvalid_i && q.size() == 0));
      check("rdata1", ctrl1_rdata_o, port_rdata_i);
      check("rdata2", ctrl2_rdata_o, port_rdata_i);
      if (m_ereq) begin
        check("addr", port_addr_o, (m_s == 1) ? ctrl1_addr_i : ctrl2_addr_i);
        check("we", 32'(port_we_o), 32'(m_we));
        check("be", 32'(port_be_o), 32'((m_s == 1) ? ctrl1_be_i : ctrl2_be_i));
        check("wdata", port_wdata_o, (m_s == 1) ? ctrl1_wdata_i : ctrl2_wdata_i);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_i) begin
      q.delete(); last_g = 2; lock_src = 0;
    end else begin
      if (port_rvalid_i && q.size() > 0) void'(q.pop_front());
      if (m_hs && !m_we) q.push_back(m_s);
      if (m_hs) begin last_g = m_s; lock_src = 0; end
      else if (m_ereq) lock_src = m_s;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    repeat (2) begin settle_check(); advance(); end
    rst_i = 0;
  endtask

  initial begin
    idle();
    rst_i = 1;
    @(negedge clk);
    do_reset();
    settle_check();
    check("rst_req", 32'(port_req_o), 32'd0);
    check("rst_err", 32'(resp_error_o), 32'd0);
    advance();

    // Single read from ctrl1.
    ctrl1_req_i = 1; ctrl1_addr_i = 32'h1000; port_gnt_i = 1;
    settle_check();
    check("t1_gnt1", 32'(ctrl1_gnt_o), 32'd1);
    check("t1_addr", port_addr_o, 32'h1000);
    advance();
    idle(); port_rvalid_i = 1; port_rdata_i = 32'hCAFE0001;
    settle_check();
    check("t1_rv1", 32'(ctrl1_rvalid_o), 32'd1);
    check("t1_rdata", ctrl1_rdata_o, 32'hCAFE0001);
    check("t1_rv2", 32'(ctrl2_rvalid_o), 32'd0);
    advance();

    // Both controllers read every cycle, responder always grants.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ctrl1_req_i = 1; ctrl1_addr_i = 32'h100 + 32'(i);
      ctrl2_req_i = 1; ctrl2_addr_i = 32'h200 + 32'(i);
      port_gnt_i = 1; port_rvalid_i = (i > 0); port_rdata_i = 32'(i);
      settle_check();
      check("t2_alt", 32'(ctrl1_gnt_o), 32'(i % 2 == 0));
      if (i > 0) check("t2_route", 32'(ctrl1_rvalid_o), 32'((i - 1) % 2 == 0));
      advance();
    end
    idle(); port_rvalid_i = 1;
    settle_check();
    check("t2_last", 32'(ctrl2_rvalid_o), 32'd1);
    advance();

    // Lock: ctrl1 stalled three cycles while ctrl2 requests.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ctrl1_req_i = 1; ctrl1_addr_i = 32'h2000;
      ctrl2_req_i = (i >= 1); ctrl2_addr_i = 32'h3000;
      port_gnt_i = (i == 3);
      settle_check();
      check("t3_addr", port_addr_o, 32'h2000);
      advance();
    end
    ctrl1_req_i = 0; port_gnt_i = 1;
    settle_check();
    check("t3_gnt2", 32'(ctrl2_gnt_o), 32'd1);
    check("t3_addr2", port_addr_o, 32'h3000);
    advance();
    idle(); port_rvalid_i = 1;
    repeat (2) begin settle_check(); advance(); end

    // Queue full blocks a third read until a response has drained.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ctrl1_req_i = 1; ctrl1_addr_i = 32'h4000 + 32'((i < 2) ? i : 2);
      port_gnt_i = 1; port_rvalid_i = (i == 3);
      settle_check();
      check("t4_req", 32'(port_req_o), 32'(i < 2 || i == 4));
      advance();
    end
    idle(); port_rvalid_i = 1;
    repeat (2) begin settle_check(); advance(); end

    // Write from ctrl2 is untracked; read from ctrl1 gets the only response.
    do_reset();
    ctrl2_req_i = 1; ctrl2_we_i = 1; ctrl2_addr_i = 32'h5000; ctrl2_wdata_i = 32'h12345678;
    ctrl2_be_i = 4'hF; port_gnt_i = 1;
    settle_check(); advance();
    idle(); ctrl1_req_i = 1; ctrl1_addr_i = 32'h5004; port_gnt_i = 1;
    settle_check(); advance();
    idle(); port_rvalid_i = 1;
    settle_check();
    check("t5_rv1", 32'(ctrl1_rvalid_o), 32'd1);
    check("t5_rv2", 32'(ctrl2_rvalid_o), 32'd0);
    advance();
    settle_check();
    check("t5_err", 32'(resp_error_o), 32'd1);
    advance();

    // Reset with two reads outstanding orphans their responses.
    idle(); ctrl1_req_i = 1; port_gnt_i = 1;
    repeat (2) begin settle_check(); advance(); end
    do_reset();
    idle(); port_rvalid_i = 1;
    repeat (2) begin
      settle_check();
      check("t6_err", 32'(resp_error_o), 32'd1);
      check("t6_rv1", 32'(ctrl1_rvalid_o), 32'd0);
      advance();
    end

    // Randomized OBI-compliant traffic.
    idle();
    for (int i = 0; i < 3000; i++) begin
      if (!ctrl1_req_i || m_g1) begin
        ctrl1_req_i = 1'($urandom % 2); ctrl1_addr_i = $urandom; ctrl1_we_i = ($urandom % 3) == 0;
        ctrl1_be_i = 4'($urandom); ctrl1_wdata_i = $urandom;
      end
      if (!ctrl2_req_i || m_g2) begin
        ctrl2_req_i = 1'($urandom % 2); ctrl2_addr_i = $urandom; ctrl2_we_i = ($urandom % 3) == 0;
        ctrl2_be_i = 4'($urandom); ctrl2_wdata_i = $urandom;
      end
      port_gnt_i    = ($urandom % 4) != 0;
      port_rvalid_i = (q.size() > 0) ? 1'($urandom % 2) : (($urandom % 10) == 0);
      port_rdata_i  = $urandom;
      rst_i         = ($urandom % 300) == 0;
      if (rst_i) begin m_g1 = 0; m_g2 = 0; end
      settle_check();
      advance();
      if (rst_i) begin ctrl1_req_i = 0; ctrl2_req_i = 0; end
      rst_i = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
